// File: rtl/orb_pkg.sv
// ---------------------------------------------------------------------------
// orb_pkg
// Shared constants and helpers for the ORB feature pipeline.
//   - default patch radius, pixel width, moment output width, output shift
//   - patch_moment FSM state type
//   - UMAX row half-width table of the circular patch for the default radius,
//     plus a constant function that derives it for any radius
//   - width helpers for the patch-moment coordinate and accumulator
// ---------------------------------------------------------------------------
package orb_pkg;

   localparam int PATCH_R_DEF = 18;
   localparam int PIX_W_DEF   = 8;
   localparam int BW_OUT_DEF  = 12;
   localparam int SHIFT_DEF   = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } pm_state_e;

   // UMAX[v] = floor(sqrt(R^2 - v^2)) for R = PATCH_R_DEF
   localparam int UMAX [0:PATCH_R_DEF] = '{
      18, 17, 17, 17, 17, 17, 16, 16, 16, 15,
      14, 14, 13, 12, 11,  9,  8,  5,  0
   };

   // Largest u with u^2 + v^2 <= r^2 (same rule as UMAX, any radius).
   function automatic int umax_calc(input int r, input int v);
      int u;
      u = 0;
      for (int k = 0; k <= r; k++) begin
         if (k * k + v * v <= r * r) u = k;
      end
      return u;
   endfunction

   // Signed coordinate width: holds -r..r with headroom.
   function automatic int coord_width(input int r);
      return $clog2(r) + 2;
   endfunction

   // Signed accumulator width: worst-case |sum(x*I)| over the square plus
   // sign and guard bits.
   function automatic int acc_width(input int r, input int pw);
      longint m;
      m = longint'(2 * r + 1) * ((longint'(1) << pw) - 1) * longint'(r) * longint'(r + 1) / 2;
      return $clog2(m) + 2;
   endfunction

endpackage

// File: rtl/moment_mac.sv
// ---------------------------------------------------------------------------
// moment_mac
// One axis of the patch moment: registers coord*pix (zero when the pixel is
// not valid or masked out), then loads or accumulates that product.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid, in_use  pixel present / pixel inside the patch mask
//   coord, pix        signed coordinate, unsigned intensity
//   acc_en            add the registered product into the accumulator
//   acc_load          replace the accumulator with the product (first pixel)
//   acc               signed running sum
// ---------------------------------------------------------------------------
module moment_mac #(
   parameter int CW    = 7,
   parameter int PIX_W = 8,
   parameter int AW    = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_use,
   input  logic signed [CW-1:0] coord,
   input  logic [PIX_W-1:0]     pix,
   input  logic                 acc_en,
   input  logic                 acc_load,
   output logic signed [AW-1:0] acc
);

   localparam int PW = CW + PIX_W + 1;

   logic signed [PW-1:0] prod_d, prod_q;
   logic signed [AW-1:0] acc_d, acc_q;

   always_comb begin
      prod_d = '0;
      if (in_valid && in_use) begin
         prod_d = PW'(coord) * PW'($signed({1'b0, pix}));
      end
   end

   // Loading on the first product lets a new patch follow the previous one
   // with no idle cycle and drops any partial sum from an aborted patch.
   always_comb begin
      acc_d = acc_q;
      if (acc_load) begin
         acc_d = AW'(prod_q);
      end else if (acc_en) begin
         acc_d = acc_q + AW'(prod_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/patch_moment.sv
// ---------------------------------------------------------------------------
// patch_moment
// Intensity-centroid moments of a (2R+1)x(2R+1) patch streamed in raster
// order: m10 = sum(x*I) >>> SHIFT, m01 = sum(y*I) >>> SHIFT, saturated,
// with x = col-R, y = row-R.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pix_valid       pixel qualifier, gaps allowed anywhere
//   sof             first pixel of a patch (only with pix_valid)
//   pix             unsigned intensity
//   m10, m01        signed moments, held until the next result
//   out_valid       one-cycle strobe per completed patch
// Optional build: define PATCH_CIRCLE_MASK_EN to count only pixels inside
// the circle |x| <= UMAX[|y|]; otherwise the whole square contributes.
//
// Handshake: valid-only stream, no backpressure. A pixel is accepted on a
// rising edge where pix_valid=1 and either sof=1 or a patch is in progress;
// out_valid is high for exactly one cycle when m10/m01 change.
//
// Pipeline (last pixel sampled at edge E):
//   E    stage 0 captures pixel, coordinates, mask and first/last flags
//   E+1  stage 1 registers x*I and y*I
//   E+2  stage 2 load/accumulate
//   E+3  stage 3 shift/saturate into m10/m01, out_valid=1
// ---------------------------------------------------------------------------
module patch_moment
   import orb_pkg::*;
#(
   parameter int PATCH_R = PATCH_R_DEF,
   parameter int PIX_W   = PIX_W_DEF,
   parameter int BW_OUT  = BW_OUT_DEF,
   parameter int SHIFT   = SHIFT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pix_valid,
   input  logic                     sof,
   input  logic [PIX_W-1:0]         pix,
   output logic signed [BW_OUT-1:0] m10,
   output logic signed [BW_OUT-1:0] m01,
   output logic                     out_valid
);

   localparam int SIDE  = 2 * PATCH_R + 1;
   localparam int CNT_W = $clog2(SIDE);
   localparam int CW    = coord_width(PATCH_R);
   localparam int AW    = acc_width(PATCH_R, PIX_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SIDE - 1);

   localparam logic signed [AW-1:0] SAT_HI = {{(AW - BW_OUT + 1){1'b0}}, {(BW_OUT - 1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

   // ---------------- FSM and raster counters ----------------
   pm_state_e        state_q, state_d;
   logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
   logic [CNT_W-1:0] cur_row, cur_col;
   logic             accept, is_last;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      accept  = pix_valid && (sof || (state_q == ACCUM));
      // sof always means (0,0), also as a restart inside ACCUM
      cur_row = sof ? '0 : row_q;
      cur_col = sof ? '0 : col_q;
      is_last = (cur_row == LAST) && (cur_col == LAST);
      if (accept) begin
         if (is_last) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
         end else begin
            state_d = ACCUM;
            if (cur_col == LAST) begin
               col_d = '0;
               row_d = cur_row + CNT_W'(1);
            end else begin
               col_d = cur_col + CNT_W'(1);
               row_d = cur_row;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // ---------------- coordinates and mask ----------------
   logic signed [CW-1:0] x_c, y_c;
   logic                 use_c;

   assign x_c = $signed(CW'(cur_col) - CW'(PATCH_R));
   assign y_c = $signed(CW'(cur_row) - CW'(PATCH_R));

`ifdef PATCH_CIRCLE_MASK_EN
   localparam int UW = $clog2(PATCH_R + 1);
   logic [CW-1:0] umax_tab [0:PATCH_R];
   logic [CW-1:0] abs_x, abs_y;

   for (genvar v = 0; v <= PATCH_R; v++) begin : g_umax
      assign umax_tab[v] = CW'(umax_calc(PATCH_R, v));
   end

   assign abs_x = x_c[CW-1] ? CW'(-x_c) : CW'(x_c);
   assign abs_y = y_c[CW-1] ? CW'(-y_c) : CW'(y_c);
   // |y| <= R by construction, so the narrowed index never leaves the table
   assign use_c = (abs_x <= umax_tab[abs_y[UW-1:0]]);
`else
   assign use_c = 1'b1;
`endif

   // ---------------- stage 0: input capture ----------------
   logic                 s0_vld_q, s0_vld_d;
   logic                 s0_first_q, s0_first_d;
   logic                 s0_last_q, s0_last_d;
   logic                 s0_use_q, s0_use_d;
   logic signed [CW-1:0] s0_x_q, s0_x_d, s0_y_q, s0_y_d;
   logic [PIX_W-1:0]     s0_pix_q, s0_pix_d;

   always_comb begin
      s0_vld_d   = accept;
      s0_first_d = accept && sof;
      s0_last_d  = accept && is_last;
      s0_use_d   = use_c;
      s0_x_d     = x_c;
      s0_y_d     = y_c;
      s0_pix_d   = pix;
   end

   // ---------------- stage 1/2 flag pipeline ----------------
   logic s1_vld_q, s1_vld_d;
   logic s1_first_q, s1_first_d;
   logic s1_last_q, s1_last_d;
   logic acc_last_q, acc_last_d;

   always_comb begin
      s1_vld_d   = s0_vld_q;
      s1_first_d = s0_vld_q && s0_first_q;
      s1_last_d  = s0_vld_q && s0_last_q;
      acc_last_d = s1_vld_q && s1_last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld_q   <= 1'b0;
         s0_first_q <= 1'b0;
         s0_last_q  <= 1'b0;
         s0_use_q   <= 1'b0;
         s0_x_q     <= '0;
         s0_y_q     <= '0;
         s0_pix_q   <= '0;
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         acc_last_q <= 1'b0;
      end else begin
         s0_vld_q   <= s0_vld_d;
         s0_first_q <= s0_first_d;
         s0_last_q  <= s0_last_d;
         s0_use_q   <= s0_use_d;
         s0_x_q     <= s0_x_d;
         s0_y_q     <= s0_y_d;
         s0_pix_q   <= s0_pix_d;
         s1_vld_q   <= s1_vld_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         acc_last_q <= acc_last_d;
      end
   end

   // ---------------- stage 1/2 datapath ----------------
   logic signed [AW-1:0] acc10, acc01;
   logic                 acc_en, acc_load;

   assign acc_en   = s1_vld_q;
   assign acc_load = s1_vld_q && s1_first_q;

   moment_mac #(.CW(CW), .PIX_W(PIX_W), .AW(AW)) u_mac_x (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s0_vld_q),
      .in_use   (s0_use_q),
      .coord    (s0_x_q),
      .pix      (s0_pix_q),
      .acc_en   (acc_en),
      .acc_load (acc_load),
      .acc      (acc10)
   );

   moment_mac #(.CW(CW), .PIX_W(PIX_W), .AW(AW)) u_mac_y (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s0_vld_q),
      .in_use   (s0_use_q),
      .coord    (s0_y_q),
      .pix      (s0_pix_q),
      .acc_en   (acc_en),
      .acc_load (acc_load),
      .acc      (acc01)
   );

   // ---------------- stage 3: shift, saturate, publish ----------------
   function automatic logic signed [BW_OUT-1:0] sat_out(input logic signed [AW-1:0] v);
      if (v > SAT_HI) begin
         sat_out = SAT_HI[BW_OUT-1:0];
      end else if (v < SAT_LO) begin
         sat_out = SAT_LO[BW_OUT-1:0];
      end else begin
         sat_out = v[BW_OUT-1:0];
      end
   endfunction

   logic signed [AW-1:0]     sh10, sh01;
   logic signed [BW_OUT-1:0] m10_q, m10_d, m01_q, m01_d;
   logic                     out_valid_q, out_valid_d;

   // acc_last_q marks the cycle where the accumulators hold a whole patch;
   // a following patch's first load lands one edge later, so no hazard.
   always_comb begin
      sh10        = acc10 >>> SHIFT;
      sh01        = acc01 >>> SHIFT;
      m10_d       = m10_q;
      m01_d       = m01_q;
      out_valid_d = acc_last_q;
      if (acc_last_q) begin
         m10_d = sat_out(sh10);
         m01_d = sat_out(sh01);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m10_q       <= '0;
         m01_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         m10_q       <= m10_d;
         m01_q       <= m01_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign m10       = m10_q;
   assign m01       = m01_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_patch_moment.sv
// ---------------------------------------------------------------------------
// tb_patch_moment
// Drives whole and partial patches into patch_moment, queues the expected
// m10/m01 and sampling edge of each completed patch, and compares them when
// out_valid fires. Build with PATCH_CIRCLE_MASK_EN to exercise the mask.
// ---------------------------------------------------------------------------
module tb_patch_moment;

   localparam int R      = 18;
   localparam int SIDE   = 2 * R + 1;
   localparam int NPIX   = SIDE * SIDE;
   localparam int PIX_W  = 8;
   localparam int BW_OUT = 12;
   localparam int SHIFT  = 10;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     pix_valid;
   logic                     sof;
   logic [PIX_W-1:0]         pix;
   logic signed [BW_OUT-1:0] m10;
   logic signed [BW_OUT-1:0] m01;
   logic                     out_valid;

   patch_moment #(
      .PATCH_R (R),
      .PIX_W   (PIX_W),
      .BW_OUT  (BW_OUT),
      .SHIFT   (SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .sof       (sof),
      .pix       (pix),
      .m10       (m10),
      .m01       (m01),
      .out_valid (out_valid)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [2*BW_OUT-1:0] exp_q[$];
   int                  edge_q[$];
   int                  pulses = 0;
   int                  exp_pulses = 0;

   initial begin
      logic [2*BW_OUT-1:0] e;
      int                  le;
      logic                prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_ov) check("ov_single_cycle", out_valid, 0);
         if (out_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", out_valid, 0);
            end else begin
               e  = exp_q.pop_front();
               le = edge_q.pop_front();
               check("m10", m10, $signed(e[2*BW_OUT-1:BW_OUT]));
               check("m01", m01, $signed(e[BW_OUT-1:0]));
               check("latency", cyc - le, 3);
            end
         end
         prev_ov = out_valid;
      end
   end

   // ---------------- stimulus image and model ----------------
   int img [SIDE][SIDE];

   task automatic fill(input int kind);
      for (int r = 0; r < SIDE; r++) begin
         for (int c = 0; c < SIDE; c++) begin
            case (kind)
               0:       img[r][c] = 100;
               1:       img[r][c] = (r == R && c == 2 * R) ? 255 : 0;
               2:       img[r][c] = (r == 0 && c == 0) ? 255 : 0;
               3:       img[r][c] = (c > R) ? 255 : 0;
               4:       img[r][c] = 50;
               default: img[r][c] = int'($urandom_range(255));
            endcase
         end
      end
   endtask

   function automatic longint sat(input longint v);
      longint s;
      s = v >>> SHIFT;
      if (s > 2047) s = 2047;
      if (s < -2048) s = -2048;
      return s;
   endfunction

   task automatic model(output longint e10, output longint e01);
      longint s10, s01;
      int     x, y;
      s10 = 0;
      s01 = 0;
      for (int r = 0; r < SIDE; r++) begin
         for (int c = 0; c < SIDE; c++) begin
            x = c - R;
            y = r - R;
`ifdef PATCH_CIRCLE_MASK_EN
            if (x * x + y * y <= R * R) begin
               s10 += longint'(x * img[r][c]);
               s01 += longint'(y * img[r][c]);
            end
`else
            s10 += longint'(x * img[r][c]);
            s01 += longint'(y * img[r][c]);
`endif
         end
      end
      e10 = sat(s10);
      e01 = sat(s01);
   endtask

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
         sof       = 1'b0;
      end
   endtask

   // Sends the first n pixels of img (sof on pixel 0). When push is set and
   // the whole patch is sent, queues the expected result and sampling edge.
   task automatic send(input int n, input int gap_pct, input bit push,
                       input longint a, input longint b);
      for (int k = 0; k < n; k++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'($urandom_range(1));
            pix       = PIX_W'($urandom_range(255));
         end
         @(negedge clk);
         pix_valid = 1'b1;
         sof       = (k == 0);
         pix       = PIX_W'(img[k / SIDE][k % SIDE]);
         if (push && k == NPIX - 1) begin
            exp_q.push_back({BW_OUT'(a), BW_OUT'(b)});
            edge_q.push_back(cyc + 1);
            exp_pulses++;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      check("rst_m10", m10, 0);
      check("rst_m01", m01, 0);
      check("rst_out_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      longint a, b;
      rst       = 1'b1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      pix       = '0;
      repeat (3) @(negedge clk);
      check("reset_m10", m10, 0);
      check("reset_m01", m01, 0);
      check("reset_out_valid", out_valid, 0);
      rst = 1'b0;

      // stray pixels without sof while idle must be ignored
      repeat (20) begin
         @(negedge clk);
         pix_valid = 1'b1;
         sof       = 1'b0;
         pix       = 8'hFF;
      end

      fill(0); send(NPIX, 0, 1, 0, 0);       idle(6);
      fill(1); send(NPIX, 0, 1, 4, 0);       idle(6);
      fill(2);
`ifdef PATCH_CIRCLE_MASK_EN
      send(NPIX, 0, 1, 0, 0);
`else
      send(NPIX, 0, 1, -5, -5);
`endif
      idle(6);

      fill(3);
`ifdef PATCH_CIRCLE_MASK_EN
      model(a, b);
`else
      a = 1575;
      b = 0;
`endif
      send(NPIX, 0, 1, a, b);                idle(6);
      send(NPIX, 40, 1, a, b);               idle(6);

      // 500-pixel patch restarted by a fresh sof
      fill(4); send(500, 0, 0, 0, 0);
      send(NPIX, 0, 1, 0, 0);                idle(6);

      // back-to-back patches, no idle cycle between
      fill(1); send(NPIX, 0, 1, 4, 0);
      fill(3); send(NPIX, 0, 1, a, b);       idle(8);

      // reset at pixel 700, then a clean patch
      fill(1); send(700, 10, 0, 0, 0);
      pulse_reset();
      send(NPIX, 0, 1, 4, 0);                idle(8);

      // reset while the last products are still in the pipeline
      fill(0); send(NPIX, 0, 0, 0, 0);
      pulse_reset();
      idle(10);

      // random intensities with random gaps
      repeat (2) begin
         fill(5);
         model(a, b);
         send(NPIX, 30, 1, a, b);
         idle(3);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      idle(5);
      check("drain_queue", exp_q.size(), 0);
      check("pulse_count", pulses, exp_pulses);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/patch_moment.md
PATCH_MOMENT -- requirements
Module: patch_moment

Interface
REQ-001 SHALL have parameter PATCH_R, default 18, meaning patch radius; patch is (2*PATCH_R+1) square, 37x37 by default.
REQ-002 SHALL have parameter PIX_W, default 8, meaning unsigned pixel intensity width.
REQ-003 SHALL have parameter BW_OUT, default 12, meaning signed width of the m10/m01 outputs.
REQ-004 SHALL have parameter SHIFT, default 10, meaning arithmetic right-shift applied to the accumulators before output.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pix_valid  input  1  pixel qualifier; gaps (pix_valid=0) allowed anywhere.
REQ-008 sof  input  1  first pixel of patch (row 0, col 0); meaningful only when pix_valid=1.
REQ-009 pix  input  PIX_W  intensity, raster order: row 0 (top) to row 2R, col 0 to col 2R within each row.
REQ-010 m10  output  BW_OUT  signed sum(x*I)>>SHIFT, held until next result.
REQ-011 m01  output  BW_OUT  signed sum(y*I)>>SHIFT, held until next result.
REQ-012 out_valid  output  1  one-cycle pulse per completed patch; drives the orientation stage's enable directly.

Function
REQ-013 SHALL use states IDLE, ACCUM; IDLE->ACCUM on pix_valid&sof; ACCUM->IDLE on acceptance of pixel (2R,2R); ACCUM stays ACCUM otherwise.
REQ-014 In IDLE, pixels with pix_valid=1, sof=0 SHALL be ignored.
REQ-015 Coordinates: x = col-PATCH_R, y = row-PATCH_R, signed; row/col counters advance only on accepted pixels.
REQ-016 pix_valid&sof in ACCUM SHALL discard the partial sums and restart the patch at (0,0); no out_valid for the aborted patch.
REQ-017 Pipeline: stage 1 registers x*I and y*I (zero if masked out); stage 2 accumulates; stage 3 shifts/saturates into m10/m01 and pulses out_valid.
REQ-018 Latency: last pixel sampled at edge E -> m10, m01, out_valid=1 registered at edge E+3; out_valid=0 at E+4.
REQ-019 Accumulators SHALL be signed, at least ceil(log2((2R+1)*(2^PIX_W-1)*R*(R+1)/2))+2 bits (23 for defaults); first product of a patch loads rather than adds, so back-to-back patches (sof the cycle after the last pixel) need no idle cycle.
REQ-020 Output SHALL be accumulator >>> SHIFT (floor), saturated to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
REQ-021 Product multiply: signed (log2(R)+2)-bit coordinate times zero-extended pixel; no rounding.

Reset
REQ-022 rst SHALL force state IDLE, counters 0, pipeline valid flags 0, accumulators 0, m10=0, m01=0, out_valid=0.
REQ-023 rst mid-patch SHALL abandon it with no out_valid, including for products already in the pipeline.

Configuration
REQ-024 Macro PATCH_CIRCLE_MASK_EN defined: pixel contributes only if |x| <= UMAX[|y|] (circular patch, UMAX from package).
REQ-025 Macro undefined: every pixel of the square contributes; no UMAX table instantiated.

Structure
REQ-026 Shared package orb_pkg SHALL hold PATCH_R default, UMAX row half-width table (UMAX[0]=18 for R=18), pixel/moment width constants.
REQ-027 One sub-module moment_mac (product register + load/accumulate register, instantiated twice for x and y) is natural.

Verification
REQ-028 Uniform patch, all pix=100 -> m10=0, m01=0, out_valid single pulse at E+3.
REQ-029 Only pixel (row 18, col 36)=255, rest 0 -> m10=4 (4590>>10), m01=0, both builds.
REQ-030 Only pixel (row 0, col 0)=255 -> with PATCH_CIRCLE_MASK_EN m10=0, m01=0; without, m10=-5, m01=-5.
REQ-031 No mask, cols 19..36=255, rest 0 -> m10=1575 (1613385>>10), m01=0; random pix_valid gaps give identical result.
REQ-032 500 pixels, then sof and full patch of pix=50 -> exactly one out_valid, m10=0, m01=0.
REQ-033 rst at pixel 700 then full patch as REQ-029 -> no pulse for aborted patch, then m10=4, m01=0.
